// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 13-bit CPU datapath.
// Steps FETCH -> DECODE -> EXEC -> (MEM) -> WB and drives the memory strobes,
// the program counter, the ALU controls and the register-file write enable.
// Every output is a register updated with the state, so nothing combinational
// reaches an output from an input.

module cpu_control_unit #(
   parameter int unsigned       ADDR_W      = 13,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       MEM_TIMEOUT = 16,
   parameter int unsigned       CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mem_done,
   input  logic [2:0]        opcode,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_address,
   output logic [ADDR_W-1:0] pc,
   output logic              read,
   output logic              write,
   output logic              instruction,
   output logic              instruction_type,
   output logic [2:0]        alu_op,
   output logic              alu_start,
   output logic              reg_write,
   output logic              busy,
   output logic              halted,
   output logic              fault,
   output logic [CNT_W-1:0]  retired
);

   // Sequencer states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_FAULT
   } state_t;

   // Instruction opcodes as decoded by the datapath.
   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_ADDI  = 3'b001,
      OP_SUB   = 3'b010,
      OP_AND   = 3'b011,
      OP_LOAD  = 3'b100,
      OP_STORE = 3'b101,
      OP_BEQ   = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   // The timer must be able to hold MEM_TIMEOUT itself.
   localparam int unsigned         TIMER_W    = $clog2(MEM_TIMEOUT + 1);
   // Value the timer holds during the last cycle allowed without mem_done.
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

   state_t             state;
   opcode_t            op_q;
   logic [TIMER_W-1:0] timer;
   logic               start_q;
   logic               start_edge;

   // ALU operation for each opcode: arithmetic ops pass straight through,
   // memory ops compute base + offset, BEQ compares by subtracting.
   function automatic logic [2:0] alu_op_for(input opcode_t op);
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_AND: return 3'(op);
         OP_LOAD, OP_STORE:               return 3'b001;
         OP_BEQ:                          return 3'b010;
         default:                         return 3'b000;
      endcase
   endfunction

   // Register-format instructions take operand 2 from the register file.
   function automatic logic is_r_format(input opcode_t op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_BEQ: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // Instructions that write a result back to the register file.
   function automatic logic writes_reg(input opcode_t op);
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_LOAD: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(input opcode_t op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // A start request is a 0->1 transition; a held-high start is ignored.
   assign start_edge = start & ~start_q;

   // State register and all registered outputs move together.
   // NOTE: every output is assigned here with <= on the same edge as the state,
   // so each output describes the state being entered and no output ever
   // depends combinationally on an input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         op_q             <= OP_ADD;
         timer            <= '0;
         start_q          <= 1'b0;
         pc               <= RESET_PC;
         read             <= 1'b0;
         write            <= 1'b0;
         instruction      <= 1'b0;
         instruction_type <= 1'b0;
         alu_op           <= 3'b000;
         alu_start        <= 1'b0;
         reg_write        <= 1'b0;
         busy             <= 1'b0;
         halted           <= 1'b0;
         fault            <= 1'b0;
         retired          <= '0;
      end else begin
         start_q   <= start;
         // One-cycle pulses fall back to 0 unless a transition below raises them.
         alu_start <= 1'b0;
         reg_write <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  state       <= S_FETCH;
                  read        <= 1'b1;
                  instruction <= 1'b1;
                  busy        <= 1'b1;
                  timer       <= '0;
               end
            end

            // Both memory-wait states share completion and timeout handling;
            // mem_done in the last allowed cycle still counts as completion.
            S_FETCH, S_MEM: begin
               if (mem_done) begin
                  read        <= 1'b0;
                  write       <= 1'b0;
                  instruction <= 1'b0;
                  if (state == S_FETCH) begin
                     state <= S_DECODE;
                  end else begin
                     state     <= S_WB;
                     reg_write <= writes_reg(op_q);
                  end
               end else if (timer == TIMER_LAST) begin
                  state       <= S_FAULT;
                  timer       <= timer + TIMER_W'(1);
                  read        <= 1'b0;
                  write       <= 1'b0;
                  instruction <= 1'b0;
                  busy        <= 1'b0;
                  fault       <= 1'b1;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            S_DECODE: begin
               op_q <= opcode_t'(opcode);
               if (opcode_t'(opcode) == OP_HALT) begin
                  state   <= S_HALT;
                  busy    <= 1'b0;
                  halted  <= 1'b1;
                  retired <= retired + CNT_W'(1);
               end else begin
                  state            <= S_EXEC;
                  alu_start        <= 1'b1;
                  alu_op           <= alu_op_for(opcode_t'(opcode));
                  instruction_type <= is_r_format(opcode_t'(opcode));
               end
            end

            // alu_op and instruction_type are left alone from here through WB.
            S_EXEC: begin
               if (is_mem_op(op_q)) begin
                  state       <= S_MEM;
                  read        <= (op_q == OP_LOAD);
                  write       <= (op_q == OP_STORE);
                  instruction <= 1'b0;
                  timer       <= '0;
               end else begin
                  state     <= S_WB;
                  reg_write <= writes_reg(op_q);
               end
            end

            S_WB: begin
               if ((op_q == OP_BEQ) && branch_flag) begin
                  pc <= branch_address;
               end else begin
                  pc <= pc + ADDR_W'(1);
               end
               retired     <= retired + CNT_W'(1);
               state       <= S_FETCH;
               read        <= 1'b1;
               instruction <= 1'b1;
               timer       <= '0;
            end

            // A restart from HALT resumes at the instruction after the HALT.
            S_HALT: begin
               if (start_edge) begin
                  state       <= S_FETCH;
                  pc          <= pc + ADDR_W'(1);
                  halted      <= 1'b0;
                  busy        <= 1'b1;
                  read        <= 1'b1;
                  instruction <= 1'b1;
                  timer       <= '0;
               end
            end

            // FAULT is terminal until reset; everything stays as it was entered.
            S_FAULT: begin
               state <= S_FAULT;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed testbench for cpu_control_unit. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.

`timescale 1ns/1ps

module tb_cpu_control_unit;

   localparam int ADDR_W = 13;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              mem_done;
   logic [2:0]        opcode;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_address;
   logic [ADDR_W-1:0] pc;
   logic              read;
   logic              write;
   logic              instruction;
   logic              instruction_type;
   logic [2:0]        alu_op;
   logic              alu_start;
   logic              reg_write;
   logic              busy;
   logic              halted;
   logic              fault;
   logic [CNT_W-1:0]  retired;

   int n_vec = 0;
   int n_err = 0;
   int n_alu_start = 0;
   int n_reg_write = 0;
   int n_rw_clash = 0;

   always #5 clk = ~clk;

   cpu_control_unit #(
      .ADDR_W(ADDR_W),
      .RESET_PC(13'h0000),
      .MEM_TIMEOUT(16),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .mem_done(mem_done),
      .opcode(opcode),
      .branch_flag(branch_flag),
      .branch_address(branch_address),
      .pc(pc),
      .read(read),
      .write(write),
      .instruction(instruction),
      .instruction_type(instruction_type),
      .alu_op(alu_op),
      .alu_start(alu_start),
      .reg_write(reg_write),
      .busy(busy),
      .halted(halted),
      .fault(fault),
      .retired(retired)
   );

   // Count pulse cycles just before each rising edge updates the outputs.
   always @(posedge clk) begin
      if (alu_start === 1'b1) n_alu_start++;
      if (reg_write === 1'b1) n_reg_write++;
      if (read === 1'b1 && write === 1'b1) n_rw_clash++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one instruction starting at a falling edge in the first FETCH cycle.
   // mem_wait < 0 means the instruction has no MEM phase.
   task automatic run_instr(input string tag, input logic [2:0] op,
                            input int fetch_wait, input int mem_wait,
                            input logic bflag, input logic [12:0] baddr,
                            input logic [2:0] exp_op, input logic exp_itype,
                            input logic exp_rd, input logic exp_wr, input logic exp_regw,
                            input logic [12:0] exp_pc, input logic [15:0] exp_ret);
      int as0;
      int rw0;
      as0            = n_alu_start;
      rw0            = n_reg_write;
      branch_flag    = bflag;
      branch_address = baddr;
      mem_done       = 1'b0;
      repeat (fetch_wait) @(negedge clk);
      check({tag, ".fetch"}, {read, write, instruction, fault}, 4'b1010);
      mem_done = 1'b1;
      opcode   = op;
      @(negedge clk);
      mem_done = 1'b0;
      check({tag, ".decode"}, {read, write, instruction, alu_start}, 4'b0000);
      @(negedge clk);
      check({tag, ".exec"}, {alu_start, alu_op, instruction_type}, {1'b1, exp_op, exp_itype});
      if (mem_wait >= 0) begin
         @(negedge clk);
         repeat (mem_wait) @(negedge clk);
         check({tag, ".mem"}, {read, write, instruction, alu_start}, {exp_rd, exp_wr, 2'b00});
         mem_done = 1'b1;
         @(negedge clk);
         mem_done = 1'b0;
      end else begin
         @(negedge clk);
      end
      check({tag, ".wb"}, {reg_write, read, write, alu_op, instruction_type},
            {exp_regw, 2'b00, exp_op, exp_itype});
      @(negedge clk);
      check({tag, ".pc"}, pc, exp_pc);
      check({tag, ".retired"}, retired, exp_ret);
      check({tag, ".next_fetch"}, {read, instruction, reg_write, busy}, 4'b1101);
      check({tag, ".pulses"}, {n_alu_start - as0, n_reg_write - rw0}, {32'd1, 31'd0, exp_regw});
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      start          = 1'b0;
      mem_done       = 1'b0;
      opcode         = 3'b000;
      branch_flag    = 1'b0;
      branch_address = '0;
      #1 reset = 1'b0;
      #2;
      check("rst.pc", pc, 13'h0000);
      check("rst.outs", {read, write, instruction, instruction_type, alu_op, alu_start, reg_write,
                         busy, halted, fault}, 12'h000);
      check("rst.retired", retired, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle.no_start", {busy, read}, 2'b00);

      // Start edge leaves IDLE into FETCH at the reset PC.
      start_pulse();
      check("start.fetch", {read, instruction, busy, pc}, {3'b111, 13'h0000});

      //          tag        op      fw  mw  bf    baddr    aop     it    rd    wr    rw    pc        ret
      run_instr("add",     3'b000, 1, -1, 1'b0, 13'h000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0001, 16'd1);
      run_instr("beq_t",   3'b110, 0, -1, 1'b1, 13'h0A5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 13'h00A5, 16'd2);
      run_instr("beq_nt",  3'b110, 0, -1, 1'b0, 13'h0A5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 13'h00A6, 16'd3);
      run_instr("addi",    3'b001, 2, -1, 1'b1, 13'h123, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 13'h00A7, 16'd4);
      run_instr("sub",     3'b010, 0, -1, 1'b0, 13'h000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 13'h00A8, 16'd5);
      run_instr("and",     3'b011, 0, -1, 1'b0, 13'h000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 13'h00A9, 16'd6);
      run_instr("beq_far", 3'b110, 0, -1, 1'b1, 13'h1FFF, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 13'h1FFF, 16'd7);
      run_instr("store",   3'b101, 0,  2, 1'b0, 13'h000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0000, 16'd8);
      run_instr("load",    3'b100, 0,  0, 1'b0, 13'h000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 13'h0001, 16'd9);
      run_instr("beq_4",   3'b110, 0, -1, 1'b1, 13'h004, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0004, 16'd10);

      // HALT at 0004; start is already high on entry, so only a fresh edge restarts.
      mem_done = 1'b1;
      opcode   = 3'b111;
      @(negedge clk);
      mem_done = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      check("halt.enter", {halted, busy, read, write, alu_start, reg_write}, 6'b100000);
      check("halt.pc", pc, 13'h0004);
      check("halt.retired", retired, 16'd11);
      repeat (3) @(negedge clk);
      check("halt.level_start", {halted, busy, pc}, {2'b10, 13'h0004});
      start = 1'b0;
      @(negedge clk);
      start_pulse();
      check("halt.restart", {halted, busy, read, instruction, pc}, {4'b0111, 13'h0005});

      // mem_done on the 16th FETCH cycle still makes normal progress.
      run_instr("late_done", 3'b000, 15, -1, 1'b0, 13'h000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0006, 16'd12);

      // No mem_done in FETCH: fault after exactly 16 cycles.
      mem_done = 1'b0;
      repeat (15) @(negedge clk);
      check("fetch_to.before", {fault, read}, 2'b01);
      @(negedge clk);
      check("fetch_to.fault", {fault, read, write, instruction, busy, alu_start, reg_write}, 7'b1000000);
      check("fetch_to.pc", pc, 13'h0006);
      mem_done = 1'b1;
      start    = 1'b1;
      repeat (3) @(negedge clk);
      mem_done = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      check("fetch_to.sticky", {fault, read, write, busy, pc}, {4'b1000, 13'h0006});

      // Reset clears the fault; then time out a LOAD in MEM.
      #2 reset = 1'b0;
      #1 check("fault.reset", {fault, pc}, {1'b0, 13'h0000});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_pulse();
      mem_done = 1'b1;
      opcode   = 3'b100;
      @(negedge clk);
      mem_done = 1'b0;
      repeat (2) @(negedge clk);
      check("mem_to.mem", {read, write, instruction}, 3'b100);
      repeat (15) @(negedge clk);
      check("mem_to.before", {fault, read}, 2'b01);
      @(negedge clk);
      check("mem_to.fault", {fault, read, write, reg_write, pc, retired}, {4'b1000, 13'h0000, 16'd0});

      // Reset asserted in the middle of a FETCH cycle takes effect at once.
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start_pulse();
      run_instr("pre_rst", 3'b000, 0, -1, 1'b0, 13'h000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0001, 16'd1);
      #2 reset = 1'b0;
      #1;
      check("midrst.outs", {read, instruction, busy, alu_op, instruction_type}, 7'b0000000);
      check("midrst.pc_ret", {pc, retired}, {13'h0000, 16'd0});
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst.no_restart", {read, busy, pc}, {2'b00, 13'h0000});

      check("rw_never_both", n_rw_clash, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
